// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo
//   Receive-side byte buffer between the UART receiver and the CPU's
//   memory-mapped read path. Each falling edge of rx_int marks a completed
//   frame, and that frame's rx_data byte is written into a circular FIFO.
//   The CPU reads through a first-word-fall-through port. It also sees
//   occupancy status and a sticky overflow flag.
//
//   Optional feature: define UART_RX_FIFO_IRQ_EN to add a registered
//   occupancy interrupt. It asserts when count reaches IRQ_THRESH, and it
//   also stays high while ovf is set.
//
// Ports
//   clk      system clock
//   rst      asynchronous, active-high reset
//   rx_data  received byte, stable from the fall of rx_int until the next frame
//   rx_int   receiver busy flag; a high-to-low transition means one byte is done
//   rd_en    CPU pop strobe (one byte per asserted cycle)
//   flush    synchronous FIFO clear
//   clr_ovf  clears the sticky overflow flag
//   rd_data  byte at the FIFO head, 8'h00 when empty
//   empty    FIFO holds zero bytes
//   full     FIFO holds DEPTH bytes
//   count    current occupancy, 0..DEPTH
//   ovf      sticky: a byte was dropped because the FIFO was full
//   irq      occupancy interrupt (only with UART_RX_FIFO_IRQ_EN)

module uart_rx_fifo #(
  parameter int DEPTH      = 16,
  parameter int ADDR_W     = 4,
  parameter int IRQ_THRESH = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        rx_data,
  input  logic              rx_int,
  input  logic              rd_en,
  input  logic              flush,
  input  logic              clr_ovf,
  output logic [7:0]        rd_data,
  output logic              empty,
  output logic              full,
  output logic [ADDR_W:0]   count,
  output logic              ovf
`ifdef UART_RX_FIFO_IRQ_EN
  ,
  output logic              irq
`endif
);

  localparam logic [ADDR_W:0] DEPTH_CNT = (ADDR_W+1)'(DEPTH);

  logic [7:0]        mem_q [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              empty_q, empty_d;
  logic              full_q, full_d;
  logic              ovf_q, ovf_d;
  logic              rx_int_q, rx_int_d;

  logic push, pop, wr_en, overflow;

  // Next-state logic. Flush has priority over any push or pop in the same
  // cycle. A push arriving while full is accepted only if a pop frees a slot
  // in that cycle; otherwise the byte is dropped and reported as overflow.
  always_comb begin
    rx_int_d = rx_int;
    push     = rx_int_q & ~rx_int;
    pop      = rd_en & ~empty_q;
    wr_en    = push & ~flush & (~full_q | pop);
    overflow = push & ~flush & full_q & ~pop;

    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;

    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (wr_en) wr_ptr_d = wr_ptr_q + ADDR_W'(1);
      if (pop)   rd_ptr_d = rd_ptr_q + ADDR_W'(1);
      if (wr_en && !pop)      count_d = count_q + (ADDR_W+1)'(1);
      else if (!wr_en && pop) count_d = count_q - (ADDR_W+1)'(1);
    end

    // An overflow in the same cycle as clr_ovf wins, so no drop goes unreported.
    ovf_d = ovf_q;
    if (overflow)     ovf_d = 1'b1;
    else if (clr_ovf) ovf_d = 1'b0;

    empty_d = (count_d == '0);
    full_d  = (count_d == DEPTH_CNT);
  end

  // Control state. Clearing rx_int_q on reset means that a reset taken in
  // the middle of a frame cannot be mistaken for a falling edge when reset
  // is released.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      empty_q  <= 1'b1;
      full_q   <= 1'b0;
      ovf_q    <= 1'b0;
      rx_int_q <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      empty_q  <= empty_d;
      full_q   <= full_d;
      ovf_q    <= ovf_d;
      rx_int_q <= rx_int_d;
    end
  end

  // The storage array has no reset. rd_data masks stale contents while the
  // FIFO is empty.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= rx_data;
  end

  assign rd_data = empty_q ? 8'h00 : mem_q[rd_ptr_q];
  assign empty   = empty_q;
  assign full    = full_q;
  assign count   = count_q;
  assign ovf     = ovf_q;

`ifdef UART_RX_FIFO_IRQ_EN
  localparam logic [ADDR_W:0] IRQ_CNT = (ADDR_W+1)'(IRQ_THRESH);

  logic irq_q, irq_d;

  // irq is computed from next-state values, so it rises on the same edge
  // that count reaches the threshold.
  always_comb begin
    irq_d = (count_d >= IRQ_CNT) | ovf_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) irq_q <= 1'b0;
    else     irq_q <= irq_d;
  end

  assign irq = irq_q;
`else
  logic unused_irq_thresh;
  assign unused_irq_thresh = (IRQ_THRESH > 0);
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo
//   Self-checking bench for uart_rx_fifo. A queue-based reference model
//   follows the frame, pop, flush and overflow rules. The bench drives
//   directed scenarios first and then randomized traffic. Every cycle it
//   compares all DUT outputs against the model.

module tb_uart_rx_fifo;

  localparam int DEPTH = 16;
  localparam int ADDR_W = 4;
  localparam int IRQ_T = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic [7:0]        rx_data;
  logic              rx_int;
  logic              rd_en;
  logic              flush;
  logic              clr_ovf;
  logic [7:0]        rd_data;
  logic              empty;
  logic              full;
  logic [ADDR_W:0]   count;
  logic              ovf;
`ifdef UART_RX_FIFO_IRQ_EN
  logic              irq;
`endif

  int checkCount = 0;
  int passCount  = 0;

  byte unsigned mQ[$];
  bit           mPrev;
  bit           mOvf;

  uart_rx_fifo #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .IRQ_THRESH(IRQ_T)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_int(rx_int),
    .rd_en(rd_en), .flush(flush), .clr_ovf(clr_ovf),
    .rd_data(rd_data), .empty(empty), .full(full), .count(count), .ovf(ovf)
`ifdef UART_RX_FIFO_IRQ_EN
    , .irq(irq)
`endif
  );

  always #5 clk = ~clk;

  // Compares one observed value with the value the bench expects and logs a mismatch.
  task automatic checkOutput(input string tag, input int unsigned obs, input int unsigned exp);
    checkCount++;
    if (obs == exp) passCount++;
    else $display("[TB] FAIL %s: got 'h%0h, expected 'h%0h", tag, obs, exp);
  endtask

  // Compares every DUT output with the reference model's current state.
  task automatic checkAll();
    checkOutput("count", count, mQ.size());
    checkOutput("empty", empty, (mQ.size() == 0));
    checkOutput("full", full, (mQ.size() == DEPTH));
    checkOutput("ovf", ovf, mOvf);
    checkOutput("rd_data", rd_data, (mQ.size() != 0) ? mQ[0] : 0);
`ifdef UART_RX_FIFO_IRQ_EN
    checkOutput("irq", irq, (mQ.size() >= IRQ_T) || mOvf);
`endif
  endtask

  // Advances the reference model by one clock using the applied inputs.
  task automatic modelStep(input bit ri, input byte unsigned d, input bit rde,
                           input bit fl, input bit co);
    bit push, pop, drop;
    push  = mPrev && !ri;
    mPrev = ri;
    if (fl) begin
      mQ.delete();
      if (co) mOvf = 0;
    end else begin
      pop  = rde && (mQ.size() != 0);
      drop = push && (mQ.size() == DEPTH) && !pop;
      if (pop) void'(mQ.pop_front());
      if (push && !drop) mQ.push_back(d);
      if (drop) mOvf = 1;
      else if (co) mOvf = 0;
    end
  endtask

  // Drives one cycle of inputs, clocks the DUT, updates the model, then checks the outputs.
  task automatic applyStimulus(input bit ri, input byte unsigned d, input bit rde,
                               input bit fl, input bit co);
    rx_int  = ri;
    rx_data = d;
    rd_en   = rde;
    flush   = fl;
    clr_ovf = co;
    @(posedge clk);
    modelStep(ri, d, rde, fl, co);
    #1;
    checkAll();
  endtask

  // Sends one UART frame. The optional read or flush is applied on the cycle of the falling edge.
  task automatic sendFrame(input byte unsigned d, input bit rdFall, input bit flFall);
    applyStimulus(1, d, 0, 0, 0);
    applyStimulus(1, d, 0, 0, 0);
    applyStimulus(0, d, rdFall, flFall, 0);
  endtask

  // Checks the byte at the head of the FIFO against a constant, then pops it.
  task automatic popOne(input string tag, input byte unsigned expv);
    checkOutput(tag, rd_data, expv);
    applyStimulus(0, 8'h00, 1, 0, 0);
  endtask

  initial begin
    bit ri, lastRi;
    byte unsigned rdata;
    int rdPct;

    rst = 1'b1; rx_int = 0; rx_data = 0; rd_en = 0; flush = 0; clr_ovf = 0;
    mPrev = 0; mOvf = 0;
    #3;
    checkAll();
    @(posedge clk); #1;
    rst = 1'b0;

    // Three frames are buffered, then read back in arrival order.
    sendFrame(8'h41, 0, 0);
    sendFrame(8'h42, 0, 0);
    sendFrame(8'h43, 0, 0);
    checkOutput("three_count", count, 3);
    popOne("read_41", 8'h41);
    popOne("read_42", 8'h42);
    popOne("read_43", 8'h43);
    checkOutput("drained_empty", empty, 1);
    checkOutput("drained_rd_data", rd_data, 8'h00);

    // Reading while empty has no side effects.
    for (int i = 0; i < 5; i++) applyStimulus(0, 8'h00, 1, 0, 0);
    checkOutput("empty_read_count", count, 0);
    checkOutput("empty_read_ovf", ovf, 0);

    // Overfill: the seventeenth byte is dropped and ovf is set.
    for (int i = 0; i <= 16; i++) sendFrame(byte'(i), 0, 0);
    checkOutput("ovfl_full", full, 1);
    checkOutput("ovfl_count", count, 16);
    checkOutput("ovfl_ovf", ovf, 1);
    for (int i = 0; i < 16; i++) popOne("ovfl_read", byte'(i));
    applyStimulus(0, 8'h00, 0, 0, 1);
    checkOutput("clr_ovf", ovf, 0);

    // Full FIFO with a push and a pop in the same cycle: no overflow, and the write pointer wraps.
    for (int i = 0; i < 16; i++) sendFrame(byte'(8'h20 + i), 0, 0);
    sendFrame(8'hAA, 1, 0);
    checkOutput("fullpp_count", count, 16);
    checkOutput("fullpp_ovf", ovf, 0);
    for (int i = 1; i < 16; i++) popOne("fullpp_read", byte'(8'h20 + i));
    popOne("fullpp_last_AA", 8'hAA);

    // A flush on the same cycle as a push discards everything, including that byte.
    for (int i = 0; i < 4; i++) sendFrame(byte'(8'h60 + i), 0, 0);
    sendFrame(8'h77, 0, 1);
    checkOutput("flush_count", count, 0);
    checkOutput("flush_empty", empty, 1);
    sendFrame(8'h55, 0, 0);
    popOne("after_flush_55", 8'h55);

`ifdef UART_RX_FIFO_IRQ_EN
    // Occupancy interrupt threshold.
    for (int i = 0; i < 3; i++) sendFrame(byte'(8'h90 + i), 0, 0);
    checkOutput("irq_below", irq, 0);
    sendFrame(8'h93, 0, 0);
    checkOutput("irq_at", irq, 1);
    applyStimulus(0, 8'h00, 1, 0, 0);
    checkOutput("irq_pop", irq, 0);
    applyStimulus(0, 8'h00, 0, 1, 0);
`endif

    // Reset in the middle of a frame must not cause a push on release.
    sendFrame(8'h12, 0, 0);
    applyStimulus(1, 8'h34, 0, 0, 0);
    rst = 1'b1;
    #2;
    mQ.delete(); mPrev = 0; mOvf = 0;
    checkAll();
    @(posedge clk); @(posedge clk); #1;
    rx_int = 0;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) applyStimulus(0, 8'h34, 0, 0, 0);
    checkOutput("midframe_count", count, 0);

    // Randomized traffic: a light-read phase that fills the FIFO, then a heavy-read phase.
    lastRi = 0; rdata = 0;
    for (int i = 0; i < 3000; i++) begin
      rdPct = (i < 1500) ? 10 : 45;
      ri = 1'($urandom_range(0, 1));
      if (ri && !lastRi) rdata = byte'($urandom);
      applyStimulus(ri, rdata, ($urandom_range(0, 99) < rdPct),
                    ($urandom_range(0, 99) < 2), ($urandom_range(0, 99) < 5));
      lastRi = ri;
    end

    $display("[TB] %0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
- Receive-side byte buffer between the UART receiver and the MIPS core's memory-mapped I/O read path.
- Detects end-of-frame from the receiver's rx_int and captures rx_data into a circular FIFO.
- Presents a first-word-fall-through read interface plus status and overflow reporting to the CPU.
- Decouples CPU polling latency from UART byte arrival.

Parameters:
- DEPTH, 16, number of byte entries; must be a power of two, minimum 2.
- ADDR_W, 4, pointer width; must equal log2(DEPTH).
- IRQ_THRESH, 1, occupancy level at or above which irq asserts (optional feature only); range 1..DEPTH.

Ports:
- clk  in  1  system clock
- rst  in  1  reset; asynchronous and active-high
- rx_data  in  8  received byte from UART receiver; stable from the cycle rx_int falls until the next frame completes
- rx_int  in  1  receiver busy flag; high during a frame; its falling edge marks a completed byte
- rd_en  in  1  CPU pop strobe, one byte per cycle asserted
- flush  in  1  synchronous FIFO clear
- clr_ovf  in  1  clears sticky overflow flag
- rd_data  out  8  byte at FIFO head (FWFT); 8'h00 when empty
- empty  out  1  FIFO holds zero bytes
- full  out  1  FIFO holds DEPTH bytes
- count  out  ADDR_W+1  current occupancy, 0..DEPTH
- ovf  out  1  sticky: a byte was dropped because the FIFO was full
- irq  out  1  occupancy interrupt (present only with the optional feature)

Behaviour:
- Reset (async, rst=1): wr_ptr=0, rd_ptr=0, count=0, ovf=0, rx_int_d=0, irq=0. Outputs: empty=1, full=0, rd_data=8'h00. Storage array is not reset.
- Edge detect: rx_int_d registers rx_int every cycle. push = rx_int_d & ~rx_int, one pulse per frame.
  - A high-to-low transition is required; rx_int held low across reset release produces no push.
- Push: array[wr_ptr] <= rx_data; wr_ptr wraps DEPTH-1 -> 0.
- Pop: pop = rd_en & ~empty. rd_ptr increments with wrap. rd_en while empty is ignored with no side effects.
- rd_data: combinational from array[rd_ptr] when !empty, else 8'h00.
  - A pushed byte is visible on rd_data, and empty drops, on the cycle after the push edge (1-cycle latency).
- count/full/empty are registered and update on the same edge as the pointers.
  - empty = (count==0); full = (count==DEPTH).
- Simultaneous push and pop:
  - Not empty, including full: both occur, count unchanged, no overflow.
  - Empty: pop is ignored, push occurs, count becomes 1.
- Overflow: push while full with no pop → byte dropped, pointers and count unchanged, ovf <= 1.
- ovf priority: a clr_ovf pulse clears ovf; if an overflow occurs in the same cycle, set wins.
- Flush: wr_ptr=rd_ptr=0, count=0 next cycle.
  - Flush beats a same-cycle push or pop; that byte is discarded.
  - ovf is not affected by flush.
- Arithmetic: pointers are ADDR_W-bit and wrap naturally; count is ADDR_W+1 bit and never exceeds DEPTH or underflows.
- Mid-frame reset: rst asserted while rx_int=1 clears rx_int_d, so no spurious push occurs on release.

Optional Feature:
- Macro: UART_RX_FIFO_IRQ_EN.
- Defined:
  - irq port exists; irq registered: irq <= (count_next >= IRQ_THRESH), so it rises the cycle count reaches the threshold.
  - irq is also forced to 1 while ovf=1.
  - Reset value 0.
- Undefined: irq port and logic are absent; IRQ_THRESH is unused; the CPU polls empty/count.

Test Plan:
- Reset then three frames 8'h41, 8'h42, 8'h43 (rx_int high/low pulses) → count=3, rd_data=8'h41; three rd_en pulses return 41, 42, 43, then empty=1 and rd_data=8'h00.
- rd_en asserted for 5 cycles while empty → count stays 0, pointers unchanged, no ovf.
- DEPTH=16: push bytes 0x00..0x10 (17 frames), no reads → full=1, count=16, ovf=1; reads return 0x00..0x0F (0x10 dropped); then clr_ovf → ovf=0.
- Fill to full, then push 0xAA on the same cycle as rd_en → count stays 16, ovf=0; the last byte read out is 0xAA (pointer wrap verified).
- Flush in the same cycle as a push with count=4 → count=0, empty=1, pushed byte absent; a following push of 0x55 reads back 0x55.
- UART_RX_FIFO_IRQ_EN, IRQ_THRESH=4: push 3 bytes → irq=0; 4th push → irq=1 the next cycle; one pop → irq=0. Assert rst mid-frame with rx_int=1 → all outputs at reset values, no push after release.
